// File: rtl/spi_frame_if_if.sv
// Core-side handshake of the SPI frame block: angle out to the CORDIC core, results back.
// The master side is the SPI frame block and the slave side is the CORDIC core.
interface spi_frame_if_if #(
  parameter int DATA_WIDTH_CORDIC = 16
);
  logic [DATA_WIDTH_CORDIC-1:0] o_angle;
  logic                         o_angle_valid;
  logic                         i_core_ready;
  logic [DATA_WIDTH_CORDIC-1:0] i_cos;
  logic [DATA_WIDTH_CORDIC-1:0] i_sin;
  logic                         i_result_valid;

  modport master (
    output o_angle, o_angle_valid,
    input  i_core_ready, i_cos, i_sin, i_result_valid
  );

  modport slave (
    input  o_angle, o_angle_valid,
    output i_core_ready, i_cos, i_sin, i_result_valid
  );
endinterface

// File: rtl/spi_frame_if.sv
// SPI mode-0 slave framing: receives a 32-bit frame whose top 16 bits are a CORDIC angle,
// and shifts the last buffered {cos,sin} result back out on miso during the same frame.
module spi_frame_if #(
  parameter int DATA_WIDTH_SPI    = 8,
  parameter int DATA_WIDTH_CORDIC = 16
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic miso,
  output logic data_ready,
  output logic o_overrun,
  spi_frame_if_if.master core
);

  localparam int         FRAME_BITS = 4 * DATA_WIDTH_SPI;
  localparam int         TX_BITS    = 2 * DATA_WIDTH_CORDIC;
  localparam logic [5:0] ANGLE_LAST = 6'(DATA_WIDTH_CORDIC - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, RX, HOLD} state_t;

  state_t state, state_next;

  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [2:0] cs_sync;
  logic [1:0] sample_vld;
  logic       armed;

  logic [5:0]                   bit_cnt;
  logic [DATA_WIDTH_CORDIC-1:0] rx_reg;
  logic [TX_BITS-1:0]           tx_reg;
  logic [TX_BITS-1:0]           result_buf;
  logic [DATA_WIDTH_CORDIC-1:0] angle_q;
  logic                         angle_valid_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // cs_n falls are only honoured once a genuinely sampled high has been seen, so a reset
  // released mid-frame (cs_n still low) waits for the next full cs_n cycle.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= 3'b000;
      mosi_sync  <= 2'b00;
      cs_sync    <= 3'b111;
      sample_vld <= 2'b00;
      armed      <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[1:0], sclk};
      mosi_sync  <= {mosi_sync[0], mosi};
      cs_sync    <= {cs_sync[1:0], cs_n};
      sample_vld <= {sample_vld[0], 1'b1};
      armed      <= armed | (sample_vld[1] & cs_sync[1]);
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = armed & cs_sync[2] & ~cs_sync[1];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cs_fall) state_next = RX;
      RX: begin
        if (cs_rise)                                  state_next = IDLE;
        else if (sclk_rise && bit_cnt == FRAME_LAST) state_next = HOLD;
      end
      HOLD: if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fall with bit_cnt still 0 precedes any rise and must not consume the first tx bit.
  // tx is cleared on the final rise so miso idles low while the master finishes the frame.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      result_buf    <= '0;
      angle_q       <= '0;
      angle_valid_q <= 1'b0;
      data_ready    <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      angle_valid_q <= 1'b0;

      if (core.i_result_valid) begin
        result_buf <= {core.i_cos, core.i_sin};
        data_ready <= 1'b1;
      end

      if (state == IDLE && cs_fall) begin
        bit_cnt    <= '0;
        tx_reg     <= core.i_result_valid ? {core.i_cos, core.i_sin} : result_buf;
        data_ready <= 1'b0;
      end else if (state == RX && !cs_rise) begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt <= ANGLE_LAST)
            rx_reg <= {rx_reg[DATA_WIDTH_CORDIC-2:0], mosi_sync[1]};
          if (bit_cnt == ANGLE_LAST) begin
            if (core.i_core_ready) begin
              angle_q       <= {rx_reg[DATA_WIDTH_CORDIC-2:0], mosi_sync[1]};
              angle_valid_q <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
          end
          if (bit_cnt == FRAME_LAST)
            tx_reg <= '0;
        end else if (sclk_fall && bit_cnt != 6'd0) begin
          tx_reg <= {tx_reg[TX_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign core.o_angle       = angle_q;
  assign core.o_angle_valid = angle_valid_q;
  assign miso               = ~cs_sync[1] & tx_reg[TX_BITS-1];

endmodule

// File: tb/tb_spi_frame_if.sv
// Directed bench for spi_frame_if: drives SPI mode-0 frames and CORDIC results,
// checking angle strobes, overrun, data_ready and the miso stream against hand values.
module tb_spi_frame_if;

  localparam int H = 6;

  logic clk;
  logic rst_n;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic miso;
  logic data_ready;
  logic o_overrun;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  spi_frame_if_if #(.DATA_WIDTH_CORDIC(16)) cif ();

  spi_frame_if #(.DATA_WIDTH_SPI(8), .DATA_WIDTH_CORDIC(16)) dut (
    .i_clk      (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .data_ready (data_ready),
    .o_overrun  (o_overrun),
    .core       (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle the strobe is high, so a stretched strobe shows up as an extra pulse.
  always @(negedge clk) if (cif.o_angle_valid === 1'b1) pulse_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pulseResult(input logic [31:0] word);
    @(negedge clk);
    cif.i_result_valid = 1'b1;
    {cif.i_cos, cif.i_sin} = word;
    @(negedge clk);
    cif.i_result_valid = 1'b0;
    @(negedge clk);
    checkOutput("data_ready_set", {31'd0, data_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] mosi_word, input int nbits,
                               input bit raise_cs, input bit coincide,
                               input logic [31:0] rv_word,
                               output logic [31:0] miso_word, output logic miso_tail);
    miso_word = '0;
    @(negedge clk);
    cs_n = 1'b0;
    if (coincide) begin
      repeat (2) @(negedge clk);
      cif.i_result_valid = 1'b1;
      {cif.i_cos, cif.i_sin} = rv_word;
      @(negedge clk);
      cif.i_result_valid = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_word[31-i];
      repeat (H) @(negedge clk);
      miso_word[31-i] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    miso_tail = miso;
    if (raise_cs) begin
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] stream;
    logic        tail;
    logic        miso_seen;
    logic [31:0] vec;
    int          p0;

    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cif.i_core_ready   = 1'b0;
    cif.i_cos          = '0;
    cif.i_sin          = '0;
    cif.i_result_valid = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_angle",      {16'd0, cif.o_angle}, 32'd0);
    checkOutput("rst_valid",      {31'd0, cif.o_angle_valid}, 32'd0);
    checkOutput("rst_data_ready", {31'd0, data_ready}, 32'd0);
    checkOutput("rst_overrun",    {31'd0, o_overrun}, 32'd0);
    checkOutput("rst_miso",       {31'd0, miso}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Basic angle reception
    cif.i_core_ready = 1'b1;
    p0 = pulse_cnt;
    applyStimulus(32'h4000_0000, 32, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f1_pulses",  32'(pulse_cnt - p0), 32'd1);
    checkOutput("f1_angle",   {16'd0, cif.o_angle}, 32'h0000_4000);
    checkOutput("f1_overrun", {31'd0, o_overrun}, 32'd0);
    checkOutput("f1_miso",    stream, 32'h0000_0000);

    // Buffered result shifted out on the next frame
    pulseResult(32'h26DD_0000);
    p0 = pulse_cnt;
    applyStimulus(32'h0000_0000, 32, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f2_miso",       stream, 32'h26DD_0000);
    checkOutput("f2_data_ready", {31'd0, data_ready}, 32'd0);
    checkOutput("f2_pulses",     32'(pulse_cnt - p0), 32'd1);
    checkOutput("f2_angle",      {16'd0, cif.o_angle}, 32'h0000_0000);

    // Core not ready: angle dropped, overrun raised; miso idles low after bit 32
    pulseResult(32'h8001_0003);
    cif.i_core_ready = 1'b0;
    p0 = pulse_cnt;
    applyStimulus(32'h1234_0000, 32, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f3_miso",      stream, 32'h8001_0003);
    checkOutput("f3_miso_tail", {31'd0, tail}, 32'd0);
    checkOutput("f3_pulses",    32'(pulse_cnt - p0), 32'd0);
    checkOutput("f3_angle",     {16'd0, cif.o_angle}, 32'h0000_0000);
    checkOutput("f3_overrun",   {31'd0, o_overrun}, 32'd1);

    cif.i_core_ready = 1'b1;
    p0 = pulse_cnt;
    applyStimulus(32'h5A5A_0000, 32, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f4_pulses",  32'(pulse_cnt - p0), 32'd1);
    checkOutput("f4_angle",   {16'd0, cif.o_angle}, 32'h0000_5A5A);
    checkOutput("f4_overrun", {31'd0, o_overrun}, 32'd1);

    // Aborted frame after 10 bits, then a full frame
    p0 = pulse_cnt;
    applyStimulus(32'hFFFF_FFFF, 10, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f5_pulses", 32'(pulse_cnt - p0), 32'd0);
    checkOutput("f5_angle",  {16'd0, cif.o_angle}, 32'h0000_5A5A);
    p0 = pulse_cnt;
    applyStimulus(32'hC000_0000, 32, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f6_pulses", 32'(pulse_cnt - p0), 32'd1);
    checkOutput("f6_angle",  {16'd0, cif.o_angle}, 32'h0000_C000);

    // Result strobe coinciding with the synchronized cs_n fall bypasses the stale buffer
    pulseResult(32'h26DD_0000);
    p0 = pulse_cnt;
    applyStimulus(32'h0001_0000, 32, 1'b1, 1'b1, 32'h1111_2222, stream, tail);
    checkOutput("f7_miso",       stream, 32'h1111_2222);
    checkOutput("f7_data_ready", {31'd0, data_ready}, 32'd0);
    checkOutput("f7_angle",      {16'd0, cif.o_angle}, 32'h0000_0001);
    checkOutput("f7_pulses",     32'(pulse_cnt - p0), 32'd1);

    // Reset mid-frame after 20 bits, remaining edges must be ignored
    vec = 32'hABCD_1234;
    p0 = pulse_cnt;
    applyStimulus(vec, 20, 1'b0, 1'b0, 32'h0, stream, tail);
    checkOutput("f8_pre_angle", {16'd0, cif.o_angle}, 32'h0000_ABCD);
    pulseResult(32'h3333_4444);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("f8_rst_angle",      {16'd0, cif.o_angle}, 32'd0);
    checkOutput("f8_rst_valid",      {31'd0, cif.o_angle_valid}, 32'd0);
    checkOutput("f8_rst_data_ready", {31'd0, data_ready}, 32'd0);
    checkOutput("f8_rst_overrun",    {31'd0, o_overrun}, 32'd0);
    checkOutput("f8_rst_miso",       {31'd0, miso}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    miso_seen = 1'b0;
    for (int i = 20; i < 32; i++) begin
      mosi = vec[31-i];
      repeat (H) @(negedge clk);
      miso_seen = miso_seen | miso;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    checkOutput("f8_tail_pulses", 32'(pulse_cnt - p0), 32'd0);
    checkOutput("f8_tail_angle",  {16'd0, cif.o_angle}, 32'd0);
    checkOutput("f8_tail_miso",   {31'd0, miso_seen}, 32'd0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);

    p0 = pulse_cnt;
    applyStimulus(32'h7FFF_0000, 32, 1'b1, 1'b0, 32'h0, stream, tail);
    checkOutput("f9_pulses",  32'(pulse_cnt - p0), 32'd1);
    checkOutput("f9_angle",   {16'd0, cif.o_angle}, 32'h0000_7FFF);
    checkOutput("f9_miso",    stream, 32'h0000_0000);
    checkOutput("f9_overrun", {31'd0, o_overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_if.md
SPI_FRAME_IF -- requirements
Module: spi_frame_if

Interface
REQ-001 Parameter DATA_WIDTH_SPI, default 8, SHALL set the SPI byte width; the frame is 4 bytes.
REQ-002 Parameter DATA_WIDTH_CORDIC, default 16, SHALL set the angle and result word width.
REQ-003 Port i_clk, input, 1 bit, SHALL be the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port sclk, input, 1 bit: SPI clock from the external master, asynchronous to i_clk.
REQ-006 Port mosi, input, 1 bit: SPI serial data in.
REQ-007 Port cs_n, input, 1 bit: SPI chip select, active low.
REQ-008 Port miso, output, 1 bit: SPI serial data out.
REQ-009 Port o_angle, output, 16 bits: received angle word, two's complement.
REQ-010 Port o_angle_valid, output, 1 bit: one-cycle strobe, o_angle is valid.
REQ-011 Port i_core_ready, input, 1 bit: CORDIC core can accept an angle.
REQ-012 Port i_cos and i_sin, inputs, 16 bits each: CORDIC results.
REQ-013 Port i_result_valid, input, 1 bit: one-cycle strobe, i_cos and i_sin are valid.
REQ-014 Port data_ready, output, 1 bit: an unread result is buffered.
REQ-015 Port o_overrun, output, 1 bit: sticky flag, an angle was dropped.

Function
REQ-016 sclk, mosi and cs_n SHALL each pass a 2-flop synchronizer; reset values are 0, 0 and 1.
REQ-017 Rise and fall SHALL be detected by comparing synchronized sclk with a third delayed flop; at most one edge per i_clk.
REQ-018 The frame protocol is SPI mode 0: MSB first, sample on sclk rise, shift on sclk fall; sclk high and low phases are each at least 4 i_clk periods.
REQ-019 The master waits at least 4 i_clk periods after cs_n falls before the first sclk rise.
REQ-020 The FSM SHALL have three states: IDLE, RX and HOLD; it enters IDLE on reset.
REQ-021 IDLE to RX SHALL occur on the synchronized cs_n falling edge; bit_cnt (6 bits) is cleared.
REQ-022 In RX, each sclk rise SHALL shift mosi into a 16-bit rx register LSB-side and increment bit_cnt.
REQ-023 On the rise that brings bit_cnt to 16, and only if i_core_ready=1, the next cycle SHALL hold o_angle = rx register and o_angle_valid=1 for exactly one cycle.
REQ-024 If i_core_ready=0 at that point, the angle SHALL be dropped and o_overrun set; o_overrun clears only on reset.
REQ-025 Rises 17-32 SHALL be counted but their mosi bits ignored; after rise 32 the FSM moves to HOLD.
REQ-026 HOLD SHALL ignore all sclk edges.
REQ-027 A synchronized cs_n rise in RX or HOLD SHALL return the FSM to IDLE; in RX with bit_cnt<16 the partial word is discarded, with no strobe.
REQ-028 o_angle SHALL hold its last value until the next strobe.
REQ-029 On i_result_valid, {i_cos,i_sin} SHALL be captured into a 32-bit result buffer and data_ready set to 1 the next cycle; a new capture overwrites an unread one.
REQ-030 On the cs_n falling edge, the 32-bit tx shift register SHALL load from the result buffer and data_ready clears.
REQ-031 If i_result_valid coincides with the cs_n falling edge, tx SHALL load the incoming {i_cos,i_sin} directly, and data_ready is 0.
REQ-032 miso SHALL equal tx[31] while synchronized cs_n=0, and 0 otherwise.
REQ-033 Each sclk fall in RX SHALL shift tx left, filling with 0; the first fall after cs_n low is ignored only if it precedes any rise.
REQ-034 After 32 bits, miso SHALL output 0 until cs_n rises.

Reset
REQ-035 With rst_n=0, asynchronously: FSM=IDLE, bit_cnt=0, rx/tx/result buffer=0, o_angle=0, o_angle_valid=0, data_ready=0, o_overrun=0, miso=0, and synchronizers at their reset values.
REQ-036 After rst_n rises mid-frame with cs_n still low, the block SHALL stay in IDLE until cs_n goes high and then low again.

Verification
REQ-037 Frame mosi=0x4000_0000, i_core_ready=1 -> one o_angle_valid pulse, o_angle=0x4000, o_overrun=0.
REQ-038 i_result_valid with cos=0x26DD, sin=0x0000 -> data_ready=1; next frame -> miso stream 0x26DD0000 and data_ready=0 after the cs_n fall.
REQ-039 i_core_ready=0 during a frame with angle 0x1234 -> no strobe, o_overrun=1 stays set until reset.
REQ-040 cs_n rises after 10 bits -> no strobe; the next full frame with angle 0xC000 -> o_angle=0xC000.
REQ-041 i_result_valid in the same cycle as the synchronized cs_n fall, with cos=0x1111, sin=0x2222 -> miso stream 0x11112222 and data_ready=0.
REQ-042 rst_n pulsed low after 20 bits -> all outputs 0; the remaining edges are ignored, and the next cs_n cycle receives normally.
